// File: rtl/dct2d_seq_if.sv
// Handshake and control bundle between the 2-D DCT sequencer and its
// upstream source / downstream datapath stages.
interface dct2d_seq_if #(
    parameter int BLK_W = 16
) ();
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             stage1_en;
    logic             trb_en;
    logic             stage2_en;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic [BLK_W-1:0] blocks_done;
    logic             err_partial;

    modport master (
        output in_valid, in_last,
        input  in_ready, stage1_en, trb_en, stage2_en,
        input  out_valid, out_last, busy, blocks_done, err_partial
    );

    modport slave (
        input  in_valid, in_last,
        output in_ready, stage1_en, trb_en, stage2_en,
        output out_valid, out_last, busy, blocks_done, err_partial
    );
endinterface

// File: rtl/dct2d_seq.sv
// Stream sequencer for the row stage -> transpose buffer -> column stage DCT
// pipeline: stall-tolerant clock-enables, end-of-stream drain, block framing.
module dct2d_seq #(
    parameter int N          = 8,
    parameter int STAGE1_LAT = 48,
    parameter int TRB_LAT    = 64,
    parameter int STAGE2_LAT = 48,
    parameter int BLK_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    dct2d_seq_if.slave bus
);
    localparam int L  = STAGE1_LAT + TRB_LAT + STAGE2_LAT;
    localparam int FW = $clog2(L + 1);
    localparam int CW = $clog2(N * N);

    localparam logic [FW-1:0] FILL_MAX  = FW'(L);
    localparam logic [FW-1:0] TRB_ON    = FW'(STAGE1_LAT);
    localparam logic [FW-1:0] ST2_ON    = FW'(STAGE1_LAT + TRB_LAT);
    localparam logic [FW-1:0] DRAIN_END = FW'(L - 1);
    localparam logic [CW-1:0] CNT_END   = CW'(N * N - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nxt;
    logic [FW-1:0]    drain;
    logic [CW-1:0]    in_cnt;
    logic [CW-1:0]    out_cnt;
    logic [BLK_W-1:0] blk_cnt;
    logic             err_q;

    logic in_drain;
    logic ready;
    logic accept;
    logic adv;
    logic ov;
    logic ol;

    // Every combinational output is held low while rst is asserted, so a
    // mid-stream reset cannot leak an enable from the abandoned state.
    assign in_drain = (state == S_DRAIN);
    assign ready    = !rst && !in_drain;
    assign accept   = bus.in_valid && ready;
    assign adv      = in_drain ? !rst : accept;
    assign ov       = adv && (fill >= FILL_MAX);
    assign ol       = ov && (out_cnt == CNT_END);

    assign bus.in_ready    = ready;
    assign bus.stage1_en   = adv && (state != S_IDLE || accept);
    assign bus.trb_en      = adv && (fill >= TRB_ON);
    assign bus.stage2_en   = adv && (fill >= ST2_ON);
    assign bus.out_valid   = ov;
    assign bus.out_last    = ol;
    assign bus.busy        = !rst && (state != S_IDLE);
    assign bus.blocks_done = rst ? '0 : blk_cnt;
    assign bus.err_partial = !rst && err_q;

    // fill counts advances since leaving IDLE and stops at L: once saturated
    // every further advance carries a valid output sample.
    always_comb begin
        fill_nxt = fill;
        if (adv && fill != FILL_MAX)
            fill_nxt = fill + FW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            fill    <= '0;
            drain   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            blk_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            fill <= fill_nxt;
            if (accept)
                in_cnt <= in_cnt + CW'(1);
            if (ov)
                out_cnt <= out_cnt + CW'(1);
            if (ol)
                blk_cnt <= blk_cnt + BLK_W'(1);
            if (accept && bus.in_last && in_cnt != CNT_END)
                err_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (accept)
                        state <= bus.in_last ? S_DRAIN : S_FILL;
                end
                S_FILL: begin
                    if (accept && bus.in_last)
                        state <= S_DRAIN;
                    else if (fill_nxt == FILL_MAX)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (accept && bus.in_last)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    drain <= drain + FW'(1);
                    // L drain advances flush the last accepted sample out
                    // of stage 2; a trailing partial block leaves out_cnt
                    // mid-count, so it is cleared here too.
                    if (drain == DRAIN_END) begin
                        state   <= S_IDLE;
                        fill    <= '0;
                        drain   <= '0;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    a_enable_order: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid |-> (bus.stage2_en && bus.trb_en && bus.stage1_en));
    a_drain_blocks: assert property (@(posedge clk) disable iff (rst)
        (state == S_DRAIN) |-> !bus.in_ready);
    a_fill_bound: assert property (@(posedge clk) disable iff (rst)
        fill <= FILL_MAX);
endmodule

// File: tb/tb_dct2d_seq.sv
// Randomized scoreboard bench for dct2d_seq: a stream-level model predicts
// handshake, enables and framing; a small second instance checks timing at N=4.
module tb_dct2d_seq;
    localparam int N   = 8;
    localparam int S1  = 48;
    localparam int TRB = 64;
    localparam int S2  = 48;
    localparam int L   = S1 + TRB + S2;
    localparam int NN  = N * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct2d_seq_if #(.BLK_W(16)) b ();
    dct2d_seq_if #(.BLK_W(16)) b4 ();

    dct2d_seq #(.N(N), .STAGE1_LAT(S1), .TRB_LAT(TRB), .STAGE2_LAT(S2), .BLK_W(16))
        dut (.clk(clk), .rst(rst), .bus(b));

    dct2d_seq #(.N(4), .STAGE1_LAT(3), .TRB_LAT(16), .STAGE2_LAT(3), .BLK_W(16))
        dut4 (.clk(clk), .rst(rst), .bus(b4));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stream-level model: each accepted sample is due out L advances later;
    // out_last marks every N*N-th sample of a stream.
    typedef struct {
        int due;
        bit last;
    } exp_t;

    exp_t        q[$];
    int          m_drain      = 0;
    int          m_stream_adv = 0;
    int          m_in_idx     = 0;
    logic [15:0] m_blocks     = '0;
    bit          m_err        = 1'b0;
    bit          acc_flag     = 1'b0;

    always @(negedge clk) begin
        bit   was_drain, exp_ready, acc, advc, exp_ov;
        int   k;
        exp_t e;
        if (rst) begin
            chk("reset_outputs",
                {b.in_ready, b.stage1_en, b.trb_en, b.stage2_en, b.out_valid,
                 b.out_last, b.busy, b.err_partial, b.blocks_done}, 0);
            q.delete();
            m_drain = 0; m_stream_adv = 0; m_in_idx = 0;
            m_blocks = '0; m_err = 1'b0; acc_flag = 1'b0;
        end else begin
            was_drain = (m_drain > 0);
            exp_ready = !was_drain;
            acc       = b.in_valid && exp_ready;
            advc      = acc || was_drain;
            k         = m_stream_adv + 1;
            exp_ov    = advc && q.size() > 0 && q[0].due == k;
            chk("in_ready",    b.in_ready,    exp_ready);
            chk("stage1_en",   b.stage1_en,   advc);
            chk("trb_en",      b.trb_en,      advc && k > S1);
            chk("stage2_en",   b.stage2_en,   advc && k > S1 + TRB);
            chk("out_valid",   b.out_valid,   exp_ov);
            chk("busy",        b.busy,        m_stream_adv > 0);
            chk("blocks_done", b.blocks_done, m_blocks);
            chk("err_partial", b.err_partial, m_err);
            if (exp_ov) begin
                e = q.pop_front();
                chk("out_last", b.out_last, e.last);
                if (e.last) m_blocks = m_blocks + 16'd1;
            end else begin
                chk("out_last_quiet", b.out_last, 0);
            end
            if (acc) begin
                q.push_back('{due: k + L, last: (m_in_idx % NN) == NN - 1});
                if (b.in_last) begin
                    if ((m_in_idx % NN) != NN - 1) m_err = 1'b1;
                    m_drain = L;
                end
                m_in_idx++;
            end
            if (advc) m_stream_adv++;
            if (was_drain) begin
                m_drain--;
                if (m_drain == 0) begin
                    m_stream_adv = 0;
                    m_in_idx     = 0;
                end
            end
            acc_flag = acc;
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic send(input bit last);
        int n = 0;
        b.in_valid = 1'b1;
        b.in_last  = last;
        forever begin
            @(posedge clk);
            if (acc_flag) break;
            if (++n > 1000) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        #1;
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle after each sample, 2 random.
    task automatic stream(input int len, input int gap_mode, input bit with_last);
        for (int i = 0; i < len; i++) begin
            send(with_last && i == len - 1);
            if (gap_mode == 1) idle(1);
            else if (gap_mode == 2) idle($urandom_range(0, 2));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_drain != 0 || m_stream_adv != 0) begin
            @(posedge clk);
            if (++n > 2000) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
        #1;
    endtask

    initial begin
        int f_trb, f_s2, f_ov, n_ov, n_last, n_dr;
        b.in_valid  = 1'b0; b.in_last  = 1'b0;
        b4.in_valid = 1'b0; b4.in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Small configuration: L = 22, one 16-sample block back-to-back.
        f_trb = 0; f_s2 = 0; f_ov = 0; n_ov = 0; n_last = 0; n_dr = 0;
        for (int c = 1; c <= 45; c++) begin
            b4.in_valid = (c <= 16);
            b4.in_last  = (c == 16);
            @(negedge clk);
            if (b4.trb_en    && f_trb == 0) f_trb = c;
            if (b4.stage2_en && f_s2  == 0) f_s2  = c;
            if (b4.out_valid && f_ov  == 0) f_ov  = c;
            if (b4.out_valid) n_ov++;
            if (b4.out_last)  n_last++;
            if (!b4.in_ready) n_dr++;
            @(posedge clk);
            #1;
        end
        b4.in_valid = 1'b0; b4.in_last = 1'b0;
        chk("n4_first_trb_en",    f_trb, 4);
        chk("n4_first_stage2_en", f_s2, 20);
        chk("n4_first_out_valid", f_ov, 23);
        chk("n4_out_valid_count", n_ov, 16);
        chk("n4_out_last_count",  n_last, 1);
        chk("n4_drain_cycles",    n_dr, 22);
        chk("n4_blocks_done",     b4.blocks_done, 1);
        chk("n4_idle",            {b4.busy, b4.err_partial, b4.in_ready}, 3'b001);

        stream(64, 0, 1);  wait_idle();
        stream(64, 1, 1);  wait_idle();
        // Next stream is presented while the 3-block stream drains.
        stream(192, 0, 1);
        stream(100, 0, 1); wait_idle();
        stream(64, 0, 1);  wait_idle();
        stream(1, 0, 1);   wait_idle();
        repeat (3) begin
            stream($urandom_range(2, 150), 2, 1);
            wait_idle();
        end
        stream(130, 2, 1);
        stream(64, 2, 1);  wait_idle();

        // Reset with fill = 100 in FILL abandons the stream.
        stream(100, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);
        stream(64, 0, 1);  wait_idle();
        idle(3);

        chk("queue_empty",  q.size(), 0);
        chk("blocks_final", b.blocks_done, m_blocks);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dct2d_seq.md
Name: dct2d_seq

Overview:
- Parametrised stream sequencer for the 2-D DCT datapath: row 1-D stage → transpose buffer → column 1-D stage.
- Replaces free-running, enable-only sequencing with:
  - valid/ready input handshake;
  - stall-tolerant pipeline advance;
  - an explicit drain on end-of-stream;
  - block framing of the output (out_last, block counter).
- Drives the clock-enables of the existing stages. It does not touch sample data, so any N×N block size and stage latency can be used.

Parameters:
- N, 8, block dimension; power of two, ≥2; block holds N*N samples.
- STAGE1_LAT, 48, advance cycles from a sample entering stage 1 to its result reaching the transpose buffer.
- TRB_LAT, 64, advance cycles through the transpose buffer.
- STAGE2_LAT, 48, advance cycles through stage 2.
- BLK_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- in_valid  in  1  upstream sample present
- in_last  in  1  qualifies the accepted sample as final sample of stream
- in_ready  out  1  sequencer accepts a sample this cycle
- stage1_en  out  1  clock-enable, row stage
- trb_en  out  1  clock-enable, transpose buffer
- stage2_en  out  1  clock-enable, column stage
- out_valid  out  1  stage-2 output sample valid this cycle
- out_last  out  1  out_valid sample is last of an N*N block
- busy  out  1  state != IDLE
- blocks_done  out  BLK_W  completed output blocks since reset, wraps
- err_partial  out  1  sticky: stream ended on a non-block boundary

Behaviour:
- Reset: state=IDLE, fill=0, drain=0, in_cnt=0, out_cnt=0, blocks_done=0, err_partial=0.
  - All outputs are 0 during and after reset, except in_ready=1 once in IDLE after reset.
  - Reset mid-stream abandons all in-flight data; no out_valid follows.
- L = STAGE1_LAT+TRB_LAT+STAGE2_LAT (default 160).
- accept = in_valid & in_ready.
- adv = accept in IDLE/FILL/RUN; adv = 1 every cycle in DRAIN.
  - Outputs below are combinational from registered state and in_valid.
- fill: counter of adv cycles since leaving IDLE, width clog2(L+1), saturates at L.
- stage1_en = adv & (state != IDLE or accept).
- trb_en = adv & (fill ≥ STAGE1_LAT).
- stage2_en = adv & (fill ≥ STAGE1_LAT+TRB_LAT).
- out_valid = adv & (fill ≥ L).
  - First out_valid coincides with the (L+1)th advance; latency is L advances, not L cycles.
  - in_valid gaps stall every stage; no bubbles appear in the output.
- FSM:
  - IDLE: in_ready=1. On accept → FILL (fill←1), or → DRAIN if in_last.
  - FILL: in_ready=1. On adv, fill++. When fill reaches L → RUN. Accept with in_last → DRAIN.
  - RUN: in_ready=1. Accept with in_last → DRAIN.
  - DRAIN: in_ready=0, adv=1 each cycle, drain++ (drain starts at 0 on entry), fill continues and saturates. When drain = L-1 → IDLE; fill, drain and in_cnt cleared. Exactly L drain cycles.
- in_cnt, out_cnt: mod N*N.
  - in_cnt increments on accept.
  - out_cnt increments on out_valid.
  - out_last = out_valid & (out_cnt == N*N-1).
  - blocks_done increments on out_last.
- End of stream: if in_last is accepted with in_cnt != N*N-1, err_partial is set.
  - Drain proceeds normally; the trailing partial block produces no out_last.
  - out_cnt is cleared on the return to IDLE.
  - err_partial clears only on rst.
- in_valid without in_last is unbounded: stream may run indefinitely in RUN.
- in_last on the very first sample: IDLE→DRAIN directly; single sample flushed; err_partial set (N≥2).
- in_valid during DRAIN is ignored (not accepted); upstream holds the sample until IDLE.

Test Plan:
- Defaults, 64 back-to-back samples, in_last on 64th:
  - first out_valid 160 cycles after first accept;
  - exactly 64 out_valid;
  - out_last on 64th;
  - blocks_done=1, err_partial=0;
  - IDLE, in_ready=1, 160 cycles after in_last accepted.
- Same stream with in_valid deasserted every other cycle:
  - first out_valid on 161st advance;
  - stage enables low on every stall cycle;
  - same 64 outputs, no gaps in advance count.
- 3 blocks (192 samples) continuous, in_last on 192nd:
  - out_last exactly at outputs 64, 128, 192;
  - blocks_done=3;
  - in_ready=0 for exactly 160 cycles of DRAIN.
- 100 samples, in_last on 100th:
  - err_partial=1;
  - one out_last (output 64), blocks_done=1;
  - 100 out_valid total;
  - next stream of 64 gives out_last on its 64th output.
- rst pulsed at fill=100 in FILL:
  - next cycle all enables 0, busy=0, blocks_done=0;
  - no out_valid afterwards until a new stream fills 160 advances.
- N=4, STAGE1_LAT=3, TRB_LAT=16, STAGE2_LAT=3, 16 samples with in_last:
  - trb_en first high on 4th advance, stage2_en on 20th, out_valid on 23rd;
  - one out_last, blocks_done=1.
